// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory arbiter between instruction fetch and data access with starvation guard and timeout
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        arb_err
);

    typedef enum logic [1:0] {IDLE, IACC, DACC, ERR} state_t;

    localparam logic [2:0] STARVE_MAX  = 3'(STARVE_LIMIT);
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] lat_addr;
    logic [31:0] lat_store;
    logic        lat_write;
    logic [3:0]  wait_cnt;
    logic [2:0]  starve_cnt;
    logic        data_req;
    logic        cur_req;
    logic        grant_i, grant_d, wait_inc;

    assign data_req = dREN | dWEN;

    // Data wins unless the fetch side has been passed over STARVE_LIMIT times;
    // with no fetch pending, data is never held back.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        wait_inc   = 1'b0;
        cur_req    = (state == IACC) ? iREN : data_req;
        case (state)
            IDLE: begin
                if (data_req && (starve_cnt < STARVE_MAX || !iREN)) begin
                    grant_d    = 1'b1;
                    state_next = DACC;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    state_next = IACC;
                end
            end
            IACC, DACC: begin
                if (!cur_req || ram_ready) begin
                    state_next = IDLE;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_cnt == TIMEOUT_LAST)
                        state_next = ERR;
                end
            end
            default: state_next = ERR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_store  <= '0;
            lat_write  <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                lat_addr   <= iaddr;
                lat_write  <= 1'b0;
                wait_cnt   <= '0;
                starve_cnt <= '0;
            end else if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_write <= dWEN;
                wait_cnt  <= '0;
                if (iREN && starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + 3'd1;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Hits are masked by RST so an interrupted access never completes.
    always_comb begin
        ramREN   = (state == IACC) || (state == DACC && !lat_write);
        ramWEN   = (state == DACC) && lat_write;
        ramaddr  = (state == IACC || state == DACC) ? lat_addr : 32'd0;
        ramstore = ramWEN ? lat_store : 32'd0;
        ihit     = (state == IACC) && iREN && ram_ready && !RST;
        dhit     = (state == DACC) && data_req && ram_ready && !RST;
        iload    = ihit ? ramload : 32'd0;
        dload    = (dhit && !lat_write) ? ramload : 32'd0;
        arb_err  = (state == ERR);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference: who owns the memory, what was captured, how long it has waited.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    bit          m_err;
    int          m_waits;
    int          m_streak;
    logic [31:0] m_addr, m_store;
    bit          m_write;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_err = 0; m_waits = 0; m_streak = 0;
        m_addr = 0; m_store = 0; m_write = 0;
    endtask

    task automatic check_outputs();
        bit          e_ren, e_wen, e_ihit, e_dhit;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0;
        e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
        if (!m_err && m_owner == 1) begin
            e_ren  = 1;
            e_addr = m_addr;
            e_ihit = iREN && ram_ready && !RST;
            if (e_ihit) e_iload = ramload;
        end else if (!m_err && m_owner == 2) begin
            e_ren  = !m_write;
            e_wen  = m_write;
            e_addr = m_addr;
            if (m_write) e_store = m_store;
            e_dhit = (dREN || dWEN) && ram_ready && !RST;
            if (e_dhit && !m_write) e_dload = ramload;
        end
        check_eq("ramREN", 32'(ramREN), 32'(e_ren));
        check_eq("ramWEN", 32'(ramWEN), 32'(e_wen));
        check_eq("ramaddr", ramaddr, e_addr);
        check_eq("ramstore", ramstore, e_store);
        check_eq("ihit", 32'(ihit), 32'(e_ihit));
        check_eq("iload", iload, e_iload);
        check_eq("dhit", 32'(dhit), 32'(e_dhit));
        check_eq("dload", dload, e_dload);
        check_eq("arb_err", 32'(arb_err), 32'(m_err));
        check_eq("hit_excl", 32'(ihit & dhit), 32'd0);
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl, input logic rr);
        RST = r; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramload = rl; ram_ready = rr;
        #1;
        check_outputs();
    endtask

    // Advance the reference by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit data, req;
        data = dREN || dWEN;
        if (RST) begin
            model_reset();
        end else if (m_err) begin
        end else if (m_owner == 0) begin
            if (data && (m_streak < STARVE_LIMIT || !iREN)) begin
                m_owner = 2; m_addr = daddr; m_store = dstore; m_write = dWEN; m_waits = 0;
                if (iREN && m_streak < STARVE_LIMIT) m_streak++;
            end else if (iREN) begin
                m_owner = 1; m_addr = iaddr; m_write = 0; m_waits = 0; m_streak = 0;
            end
        end else begin
            req = (m_owner == 1) ? iREN : data;
            if (!req || ram_ready) begin
                m_owner = 0;
            end else begin
                m_waits++;
                if (m_waits == TIMEOUT) m_err = 1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        int ihit_cycle;
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_idle_err", 32'(arb_err), 32'd0);
        tick();

        // Fetch with ready on first access cycle
        drive(0, 1, 32'h40, 0, 0, 0, 0, 32'h1234_5678, 1); tick();
        drive(0, 1, 32'h40, 0, 0, 0, 0, 32'h1234_5678, 1);
        check_eq("s_fetch_ihit", 32'(ihit), 32'd1);
        check_eq("s_fetch_addr", ramaddr, 32'h40);
        check_eq("s_fetch_iload", iload, 32'h1234_5678);
        tick();

        // Starvation guard: both requesting, memory always ready
        do_reset();
        ihit_cycle = -1;
        for (int c = 0; c < 14; c++) begin
            drive(0, 1, 32'h100, 1, 0, 32'h200, 0, 32'(c), 1);
            if (ihit && ihit_cycle < 0) ihit_cycle = c;
            tick();
        end
        check_eq("s_starve_ihit_cycle", 32'(ihit_cycle), 32'd9);

        // Read+write together is a write
        do_reset();
        drive(0, 0, 0, 1, 1, 32'h80, 32'hDEAD_BEEF, 32'h5555_5555, 1); tick();
        drive(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h5555_5555, 1);
        check_eq("s_write_wen", 32'(ramWEN), 32'd1);
        check_eq("s_write_store", ramstore, 32'hDEAD_BEEF);
        check_eq("s_write_dhit", 32'(dhit), 32'd1);
        tick();

        // Timeout to error, requests ignored, reset recovers
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(0, 0, 0, 1, 0, 32'h300, 0, 0, 0); tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 32'h10, 1, 0, 32'h300, 0, 32'hFFFF_FFFF, 1);
            check_eq("s_timeout_err", 32'(arb_err), 32'd1);
            tick();
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("s_timeout_cleared", 32'(arb_err), 32'd0);
        tick();

        // Requester drops mid-access
        drive(0, 0, 0, 1, 0, 32'h44, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 32'h44, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 32'h44, 0, 0, 1);
        check_eq("s_abort_dhit", 32'(dhit), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("s_abort_ren", 32'(ramREN), 32'd0);
        tick();

        // Reset during a completing fetch
        drive(0, 1, 32'h60, 0, 0, 0, 0, 32'hABCD, 1); tick();
        drive(1, 1, 32'h60, 0, 0, 0, 0, 32'hABCD, 1);
        check_eq("s_rst_ihit", 32'(ihit), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'hABCD, 1);
        check_eq("s_rst_after", 32'(ramREN | ihit), 32'd0);
        tick();

        // Randomized traffic in chunks with varying memory readiness
        for (int chunk = 0; chunk < 30; chunk++) begin
            int rdy_pct;
            logic ir, dr, dw;
            rdy_pct = (chunk % 3 == 0) ? 5 : ((chunk % 3 == 1) ? 50 : 90);
            ir = 0; dr = 0; dw = 0;
            do_reset();
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(7) == 0) ir = $urandom_range(1);
                if ($urandom_range(7) == 0) dr = $urandom_range(1);
                if ($urandom_range(7) == 0) dw = ($urandom_range(3) == 0);
                drive(($urandom_range(299) == 0), ir, $urandom, dr, dw, $urandom, $urandom,
                      $urandom, ($urandom_range(99) < rdy_pct));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants allowed while iREN is pending.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum wait cycles per access before the error state.
REQ-003 The block SHALL have port CLK  input  1  system clock, all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port iREN  input  1  instruction fetch request.
REQ-006 The block SHALL have port iaddr  input  32  instruction address (word_t).
REQ-007 The block SHALL have port dREN  input  1  data read request.
REQ-008 The block SHALL have port dWEN  input  1  data write request.
REQ-009 The block SHALL have port daddr  input  32  data address (word_t).
REQ-010 The block SHALL have port dstore  input  32  data write value (word_t).
REQ-011 The block SHALL have port ihit  output  1  instruction access complete, one-cycle pulse.
REQ-012 The block SHALL have port iload  output  32  fetched instruction, valid only when ihit=1.
REQ-013 The block SHALL have port dhit  output  1  data access complete, one-cycle pulse.
REQ-014 The block SHALL have port dload  output  32  read data, valid only when dhit=1 on a read.
REQ-015 The block SHALL have port ramREN  output  1  shared memory read strobe.
REQ-016 The block SHALL have port ramWEN  output  1  shared memory write strobe.
REQ-017 The block SHALL have port ramaddr  output  32  shared memory address.
REQ-018 The block SHALL have port ramstore  output  32  shared memory write data.
REQ-019 The block SHALL have port ramload  input  32  shared memory read data.
REQ-020 The block SHALL have port ram_ready  input  1  memory completes the current access this cycle.
REQ-021 The block SHALL have port arb_err  output  1  sticky timeout error flag.

Function
REQ-022 The block SHALL implement states IDLE, IACC, DACC, ERR, held in a single registered state variable.
REQ-023 In IDLE, data pending (dREN|dWEN) with starve_cnt<STARVE_LIMIT SHALL select DACC next cycle.
REQ-024 In IDLE, iREN with no data pending, or with starve_cnt=STARVE_LIMIT, SHALL select IACC next cycle.
REQ-025 In IDLE, no request SHALL keep IDLE; all ram strobes and hits SHALL be 0 in IDLE.
REQ-026 On entry to a grant, the address, the write value and the operation SHALL be latched; ram outputs SHALL come from the latched copies, not from live inputs.
REQ-027 With dREN=dWEN=1, the grant SHALL be a write (ramWEN=1, ramREN=0).
REQ-028 In IACC, ramREN SHALL be 1; in DACC, exactly one of ramREN/ramWEN SHALL be 1 per the latched operation.
REQ-029 In IACC or DACC with ram_ready=1, the matching hit SHALL be 1 combinationally in that cycle, with iload/dload=ramload; the state SHALL return to IDLE next cycle.
REQ-030 Minimum latency SHALL be 2 cycles from request to hit (grant cycle plus one access cycle with ram_ready=1).
REQ-031 If the requester drops its request during IACC/DACC before ram_ready, the access SHALL abort: no hit, strobes 0 next cycle, return to IDLE.
REQ-032 A 4-bit wait_cnt SHALL clear on grant and increment each IACC/DACC cycle with ram_ready=0.
REQ-033 When wait_cnt reaches TIMEOUT, the next state SHALL be ERR.
REQ-034 In ERR, arb_err SHALL be 1 and all strobes and hits SHALL be 0 until RST; requests SHALL be ignored.
REQ-035 A 3-bit starve_cnt SHALL increment on each DACC grant made while iREN=1, saturate at STARVE_LIMIT, and clear on each IACC grant.
REQ-036 ihit and dhit SHALL never be 1 in the same cycle.

Reset
REQ-037 RST=1 SHALL set, at the next edge, state=IDLE, wait_cnt=0, starve_cnt=0, arb_err=0, latched address/data=0.
REQ-038 RST=1 SHALL force all outputs to 0 at that edge, including mid-access and in ERR; no hit SHALL be produced for an interrupted access.

Verification
REQ-039 Scenario: iREN=1, iaddr=0x40, ram_ready=1 on the first IACC cycle -> ramREN=1, ramaddr=0x40, ihit=1 in cycle 2, iload=ramload.
REQ-040 Scenario: iREN and dREN both held, ram_ready always 1 -> four DACC grants, then one IACC, then starve_cnt=0 and DACC again.
REQ-041 Scenario: dWEN=dREN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit pulse.
REQ-042 Scenario: dREN held, ram_ready=0 for 15 cycles -> ERR, arb_err=1 held, no dhit; RST=1 -> IDLE, arb_err=0.
REQ-043 Scenario: dREN dropped during the second DACC cycle -> no dhit, ramREN=0 next cycle, IDLE.
REQ-044 Scenario: RST=1 during IACC with ram_ready=1 in the same cycle -> outputs 0 next cycle, state IDLE, no ihit afterward.
